// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter:
// FSM state encoding, grant codes and timeout counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    // Width of the mem_ack timeout counter (TIMEOUT must fit in it).
    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick between fetch and data ports.
// On a tie the port that was not granted last wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant
);

    // Single requester wins outright; a tie alternates against last_grant.
    always_comb begin
        grant = GNT_I;
        if (i_req && d_req) begin
            grant = ~last_grant;
        end else if (d_req) begin
            grant = GNT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported, variable-latency memory between the
// instruction-fetch and data ports. Each access runs grant -> BUSY (memory
// handshake) -> RESP (one-cycle done pulse).
// Optional macro MEM_ARB_TIMEOUT_EN adds a mem_ack timeout that aborts the
// access and pulses bus_error alongside the done pulse.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_error
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT must be in 1..255");
    end

    state_t            state_q, state_d;
    logic              last_grant_q;
    logic              gnt_q;
    logic              pick;
    logic              grant_take;
    logic              ack_take;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              timeout_hit;

    rr_pick2 u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant_q),
        .grant      (pick)
    );

    assign grant_take = (state_q == IDLE) && (i_req || d_req);
    assign ack_take   = (state_q == BUSY) && mem_ack;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Count BUSY cycles without ack; an ack on the final cycle still wins.
    assign timeout_hit = (state_q == BUSY) && !mem_ack && (cnt_q == CNT_LAST);

    // Timeout counter and abort flag; err_q is only consumed in RESP.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (grant_take) begin
                cnt_q <= '0;
            end else if (state_q == BUSY && !mem_ack) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == BUSY) begin
                err_q <= timeout_hit;
            end
        end
    end

    assign bus_error = (state_q == RESP) && err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus_error   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; RESP never grants, so peak rate is one access per 3 cycles.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (i_req || d_req) state_d = BUSY;
            BUSY: if (mem_ack || timeout_hit) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant bookkeeping, memory request registers and read-data capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_q <= GNT_D;
            gnt_q        <= GNT_I;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            if (grant_take) begin
                gnt_q        <= pick;
                last_grant_q <= pick;
                if (pick == GNT_D) begin
                    mem_addr_q  <= d_addr;
                    mem_we_q    <= d_we;
                    mem_wdata_q <= d_wdata;
                end else begin
                    mem_addr_q <= i_addr;
                    mem_we_q   <= 1'b0;
                end
            end
            if (ack_take) begin
                if (gnt_q == GNT_I) begin
                    i_rdata_q <= mem_rdata;
                end else if (!mem_we_q) begin
                    d_rdata_q <= mem_rdata;
                end
            end
        end
    end

    // mem_req follows state so an asynchronous reset drops it at once.
    assign mem_req   = (state_q == BUSY);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_done    = (state_q == RESP) && (gnt_q == GNT_I);
    assign d_done    = (state_q == RESP) && (gnt_q == GNT_D);
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven single-port accesses plus
// directed sequences for tie alternation, mid-BUSY reset, spurious ack and
// the mem_ack timeout (or indefinite wait when the timeout is not built in).
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        bus_error;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .bus_error (bus_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        int          delay;
        logic [31:0] exp_i;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One single-port access; ack arrives in BUSY cycle v.delay.
    task automatic do_txn(input vec_t v);
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        tick();
        chk1("req_cycle1", mem_req, 1'b1);
        chk("addr_cycle1", mem_addr, v.addr);
        chk1("we_cycle1", mem_we, v.we);
        if (v.we) chk("wdata_cycle1", mem_wdata, v.wdata);
        // Port inputs change mid-transaction and must be ignored.
        i_addr = ~v.addr; d_addr = ~v.addr; d_wdata = ~v.wdata; d_we = ~v.we;
        for (int k = 1; k < v.delay; k++) begin
            tick();
            chk1("req_held", mem_req, 1'b1);
            chk("addr_stable", mem_addr, v.addr);
            if (v.we) chk("wdata_stable", mem_wdata, v.wdata);
            chk1("no_early_done", i_done | d_done, 1'b0);
        end
        mem_ack = 1'b1; mem_rdata = v.mrd;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        chk1("resp_req_low", mem_req, 1'b0);
        chk1("resp_i_done", i_done, !v.is_d);
        chk1("resp_d_done", d_done, v.is_d);
        chk1("resp_no_err", bus_error, 1'b0);
        chk("resp_i_rdata", i_rdata, v.exp_i);
        chk("resp_d_rdata", d_rdata, v.exp_d);
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        tick();
        chk1("idle_done_low", i_done | d_done, 1'b0);
        chk1("idle_req_low", mem_req, 1'b0);
    endtask

    // Both ports held high; entered in IDLE, returns in the following IDLE cycle.
    task automatic tie_step(input logic exp_d, input logic [31:0] rd);
        tick();
        chk("tie_addr", mem_addr, exp_d ? 32'h1001_0010 : 32'h0040_0010);
        chk1("tie_we", mem_we, 1'b0);
        mem_ack = 1'b1; mem_rdata = rd;
        tick();
        mem_ack = 1'b0;
        chk1("tie_i_done", i_done, !exp_d);
        chk1("tie_d_done", d_done, exp_d);
        chk(exp_d ? "tie_d_rdata" : "tie_i_rdata", exp_d ? d_rdata : i_rdata, rd);
        tick();
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0040_0000, 32'h0, 32'h8C02_0004, 1,
                    32'h8C02_0004, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h1001_0000, 32'h0, 32'h1234_5678, 2,
                    32'h8C02_0004, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 5,
                    32'h8C02_0004, 32'h1234_5678};
        vecs[3] = '{1'b0, 1'b0, 32'h0040_0004, 32'h0, 32'h0085_1020, 3,
                    32'h0085_1020, 32'h1234_5678};
        vecs[4] = '{1'b1, 1'b0, 32'h1001_000C, 32'h0, 32'hCAFE_F00D, 1,
                    32'h0085_1020, 32'hCAFE_F00D};

        // Reset values.
        #12;
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_i_done", i_done, 1'b0);
        chk1("rst_d_done", d_done, 1'b0);
        chk1("rst_bus_error", bus_error, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick();

        // Tie after reset: fetch, then data, then fetch again.
        i_req = 1'b1; i_addr = 32'h0040_0010;
        d_req = 1'b1; d_addr = 32'h1001_0010; d_we = 1'b0;
        tie_step(1'b0, 32'h1111_1111);
        tie_step(1'b1, 32'h2222_2222);
        tie_step(1'b0, 32'h3333_3333);
        i_req = 1'b0; d_req = 1'b0;
        tick();
        chk1("tie_end_idle", mem_req, 1'b0);

        // Reset in BUSY cycle 2 of a fetch, then re-grant after release.
        i_req = 1'b1; i_addr = 32'h0040_0020;
        tick();
        tick();
        chk1("mid_busy_req", mem_req, 1'b1);
        reset = 1'b0;
        #1;
        chk1("async_req_drop", mem_req, 1'b0);
        chk1("async_no_done", i_done, 1'b0);
        chk("async_i_rdata", i_rdata, 32'h0);
        tick();
        chk1("rst_hold_done", i_done, 1'b0);
        tick();
        chk1("rst_hold_req", mem_req, 1'b0);
        reset = 1'b1;
        tick();
        chk1("regrant_req", mem_req, 1'b1);
        chk("regrant_addr", mem_addr, 32'h0040_0020);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ack = 1'b0;
        chk1("regrant_done", i_done, 1'b1);
        chk("regrant_rdata", i_rdata, 32'h0BAD_F00D);
        i_req = 1'b0;
        tick();

        // Table-driven single-port accesses.
        for (int n = 0; n < 5; n++) begin
            do_txn(vecs[n]);
        end

        // Spurious ack in IDLE.
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        chk1("spur_req", mem_req, 1'b0);
        chk1("spur_done", i_done | d_done, 1'b0);
        chk("spur_i_rdata", i_rdata, 32'h0085_1020);
        chk("spur_d_rdata", d_rdata, 32'hCAFE_F00D);
        tick();
        chk1("spur_still_idle", mem_req, 1'b0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Load with no ack: aborted after 4 BUSY cycles.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0020;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk1("to_req_held", mem_req, 1'b1);
            chk1("to_no_err_yet", bus_error, 1'b0);
            tick();
        end
        chk1("to_req_drop", mem_req, 1'b0);
        chk1("to_d_done", d_done, 1'b1);
        chk1("to_bus_error", bus_error, 1'b1);
        chk("to_d_rdata", d_rdata, 32'hCAFE_F00D);
        d_req = 1'b0;
        tick();
        chk1("to_err_pulse", bus_error, 1'b0);
        chk1("to_done_pulse", d_done, 1'b0);

        // Ack on the timeout edge wins.
        d_req = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) tick();
        mem_ack = 1'b1; mem_rdata = 32'h600D_CAFE;
        tick();
        mem_ack = 1'b0;
        chk1("to_ack_done", d_done, 1'b1);
        chk1("to_ack_no_err", bus_error, 1'b0);
        chk("to_ack_rdata", d_rdata, 32'h600D_CAFE);
        d_req = 1'b0;
        tick();
`else
        // Without the timeout, BUSY waits as long as the memory needs.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0020;
        tick();
        for (int k = 0; k < 20; k++) begin
            chk1("wait_req_held", mem_req, 1'b1);
            chk1("wait_no_err", bus_error, 1'b0);
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 32'h600D_CAFE;
        tick();
        mem_ack = 1'b0;
        chk1("wait_done", d_done, 1'b1);
        chk1("wait_no_err_resp", bus_error, 1'b0);
        chk("wait_rdata", d_rdata, 32'h600D_CAFE);
        d_req = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the CPU instruction-fetch port and the data (load/store) port.
- Sits between the CPU core and the unified memory model. Sequences each access as grant → memory handshake → one-cycle response.
- Arbitrates round-robin when both ports request in the same cycle.
- The core stalls on its port until that port's done pulse.

Parameters:
- ADDR_W, 32, address width of both ports and the memory.
- DATA_W, 32, data width.
- TIMEOUT, 255, cycles to wait for mem_ack before aborting. Used only with MEM_ARB_TIMEOUT_EN; range 1..255.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction fetch request; level, held until i_done.
- i_addr  in  ADDR_W  fetch address (pc).
- i_done  out  1  one-cycle pulse; fetch complete, i_rdata valid.
- i_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request; level, held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address (alu_out).
- d_wdata  in  DATA_W  store data (reg_data2).
- d_done  out  1  one-cycle pulse; data access complete.
- d_rdata  out  DATA_W  load result (mem_out).
- mem_req  out  1  memory request; held high until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  one-cycle completion from memory; mem_rdata valid with it.
- mem_rdata  in  DATA_W  memory read data.
- bus_error  out  1  one-cycle pulse on timeout abort (tied 0 without the macro).

Behaviour:
- States:
  - IDLE: no grant.
  - BUSY: mem_req = 1.
  - RESP: done pulse.
- Transitions:
  - IDLE → BUSY when i_req or d_req is high at a clock edge.
  - BUSY → RESP on the edge where mem_ack = 1.
  - RESP → IDLE always, after one cycle.
- Grant is taken in IDLE only:
  - A single requester wins.
  - If both request, the port not granted last wins.
  - last_grant is a 1-bit register (0 = I, 1 = D) and resets to D, so the first tie goes to instruction fetch.
- On grant, the following are registered and driven from registers during BUSY:
  - mem_addr, mem_we, mem_wdata.
  - mem_we = 0 for fetches.
- Port inputs are not re-sampled during BUSY/RESP. A requester changing addr/data mid-transaction has no effect.
- On mem_ack, mem_rdata is captured into the granted port's rdata register:
  - Loads and fetches capture.
  - Stores leave d_rdata unchanged.
  - The rdata register holds until that port's next completion.
- In RESP, exactly one of i_done/d_done = 1 and mem_req = 0. No new grant is made in RESP, even if requests are pending.
- Minimum latency:
  - Request sampled at edge 0.
  - mem_req high in cycle 1.
  - With an ack in cycle 1, done is high in cycle 2.
  - The next grant is at edge 3.
  - Peak throughput is one access per 3 cycles.
- mem_ack outside BUSY is ignored: no state change, no capture.
- Reset values (asynchronous, reset = 0):
  - state = IDLE.
  - mem_req, mem_we, i_done, d_done, bus_error = 0.
  - mem_addr, mem_wdata, i_rdata, d_rdata = 0.
  - last_grant = D.
- Reset asserted mid-BUSY drops mem_req immediately, without waiting for a clock. The transaction is lost and no done is issued.
- A requester deasserting req before done is illegal. The arbiter completes the transaction regardless.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without mem_ack.
  - When the count reaches TIMEOUT, mem_req drops and the state goes to RESP.
  - In RESP, the granted port's done pulses with rdata unchanged, and bus_error pulses in the same cycle.
  - An ack arriving on the same edge as the timeout takes priority: normal completion, no bus_error.
- When undefined: no counter, BUSY waits indefinitely, and bus_error is tied 0.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state encoding (IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2);
  - grant codes GNT_I = 1'b0, GNT_D = 1'b1;
  - the TIMEOUT counter width constant (8).
- One natural sub-module, rr_pick2: a combinational 2-way round-robin pick from (i_req, d_req, last_grant). The FSM and datapath registers stay in mem_arbiter.

Test Plan:
- Fetch only: i_addr = 0x00400000, memory returns 0x8C020004 with an ack 1 cycle after mem_req → mem_addr = 0x00400000, mem_we = 0, i_done in cycle 2, i_rdata = 0x8C020004.
- Store with a slow memory: d_we = 1, d_addr = 0x10010008, d_wdata = 0xDEADBEEF, ack after 5 BUSY cycles → mem_req held 5 cycles with stable mem_addr/mem_wdata; d_done pulses once; d_rdata unchanged.
- Tie after reset: i_req and d_req both high at edge 0 → fetch granted first; data granted at the next IDLE; on a further tie, fetch again (alternation).
- Reset at cycle 2 of a BUSY fetch → mem_req = 0 asynchronously, no i_done; after reset release with i_req still high, the fetch is re-granted from IDLE.
- Spurious mem_ack in IDLE → no state change, no done, rdata unchanged.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT = 4, a load with no ack → mem_req drops after 4 cycles; d_done and bus_error pulse together; d_rdata unchanged.
